// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: FSM states, RV32I funct3 codes,
// access-size codes and small decode helpers.
package lsu_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC0 = 2'd1;
  localparam logic [1:0] ACC1 = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  // Stores have no unsigned variants, so BU/HU are load-only.
  function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] base_enable(input logic [1:0] size);
    logic [3:0] be;
    case (size)
      SIZE_B:  be = 4'b0001;
      SIZE_H:  be = 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Bundle of the load/store unit request, response and memory-side signals.
// The master side is the pipeline plus data memory; the slave side is the LSU.
interface lsu_if #(
  parameter int AddressWidth = 10
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_we;
  logic [31:0]             req_addr;
  logic [31:0]             req_wdata;
  logic [2:0]              req_funct3;
  logic                    rsp_valid;
  logic [31:0]             rsp_rdata;
  logic                    rsp_err;
  logic                    mem_en;
  logic                    mem_we;
  logic [AddressWidth-1:0] mem_addr;
  logic [3:0]              mem_be;
  logic [31:0]             mem_wdata;
  logic [31:0]             mem_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_funct3, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_en, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_funct3, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_en, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: byte-enable generation, store-data lane shift,
// and load-data extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] lo_i,
  input  logic [31:0] hi_i,
  output logic [7:0]  enable_o,
  output logic [63:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [4:0]  shamt;
  logic [31:0] shifted;

  assign shamt    = {off_i, 3'b000};
  assign enable_o = {4'b0000, base_enable(funct3_i[1:0])} << off_i;
  assign wdata_o  = {32'h0000_0000, wdata_i} << shamt;
  assign shifted  = 32'({hi_i, lo_i} >> shamt);

  always_comb begin
    rdata_o = shifted;
    case (funct3_i)
      F3_B:    rdata_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    rdata_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   rdata_o = {24'h000000, shifted[7:0]};
      F3_HU:   rdata_o = {16'h0000, shifted[15:0]};
      default: rdata_o = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request at a time, split into up to two word
// accesses when the byte lanes cross a word boundary.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int AddressWidth = 10
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_we_i,
  input  logic [31:0]             req_addr_i,
  input  logic [31:0]             req_wdata_i,
  input  logic [2:0]              req_funct3_i,
  output logic                    rsp_valid_o,
  output logic [31:0]             rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic                    mem_en_o,
  output logic                    mem_we_o,
  output logic [AddressWidth-1:0] mem_addr_o,
  output logic [3:0]              mem_be_o,
  output logic [31:0]             mem_wdata_o,
  input  logic [31:0]             mem_rdata_i
);

  logic [1:0]              state_q, state_d;
  logic [AddressWidth+1:0] addr_q;
  logic                    we_q;
  logic [31:0]             wdata_q;
  logic [2:0]              funct3_q;
  logic                    err_q;
  logic [31:0]             lo_q;

  logic                    accept;
  logic                    crossing;
  logic [1:0]              off;
  logic [AddressWidth-1:0] word;
  logic [AddressWidth-1:0] word_next;
  logic [7:0]              enable;
  logic [63:0]             wdata64;
  logic [31:0]             lo_sel;
  logic [31:0]             load_result;
  logic                    unused_addr_bits;

  assign unused_addr_bits = ^req_addr_i[31:AddressWidth+2];

  assign accept    = req_valid_i && req_ready_o;
  assign off       = addr_q[1:0];
  assign word      = addr_q[AddressWidth+1:2];
  assign word_next = word + {{(AddressWidth-1){1'b0}}, 1'b1};
  assign crossing  = |enable[7:4];
  // An aligned load's only word arrives in RESP; a crossing load's low word was latched in ACC1.
  assign lo_sel    = crossing ? lo_q : mem_rdata_i;

  lsu_align u_align (
    .off_i    (off),
    .funct3_i (funct3_q),
    .wdata_i  (wdata_q),
    .lo_i     (lo_sel),
    .hi_i     (mem_rdata_i),
    .enable_o (enable),
    .wdata_o  (wdata64),
    .rdata_o  (load_result)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = funct3_legal(req_we_i, req_funct3_i) ? ACC0 : RESP;
      ACC0:    state_d = crossing ? ACC1 : RESP;
      ACC1:    state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      funct3_q <= '0;
      err_q    <= 1'b0;
      lo_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q   <= req_addr_i[AddressWidth+1:0];
        we_q     <= req_we_i;
        wdata_q  <= req_wdata_i;
        funct3_q <= req_funct3_i;
        err_q    <= !funct3_legal(req_we_i, req_funct3_i);
      end
      if (state_q == ACC1) lo_q <= mem_rdata_i;
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_err_o   = (state_q == RESP) && err_q;
  assign rsp_rdata_o = ((state_q == RESP) && !we_q && !err_q) ? load_result : 32'h0000_0000;

  // Loads always read the full word; lane selection happens in lsu_align.
  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_be_o    = 4'b0000;
    mem_wdata_o = 32'h0000_0000;
    case (state_q)
      ACC0: begin
        mem_en_o    = 1'b1;
        mem_we_o    = we_q;
        mem_addr_o  = word;
        mem_be_o    = we_q ? enable[3:0] : 4'b1111;
        mem_wdata_o = we_q ? wdata64[31:0] : 32'h0000_0000;
      end
      ACC1: begin
        mem_en_o    = 1'b1;
        mem_we_o    = we_q;
        mem_addr_o  = word_next;
        mem_be_o    = we_q ? enable[7:4] : 4'b1111;
        mem_wdata_o = we_q ? wdata64[63:32] : 32'h0000_0000;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a word-addressed memory model
// and a negedge monitor logging strobes and responses.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int AW   = 10;
  localparam int MEMW = 1 << AW;

  logic clk;
  logic rst;
  lsu_if #(.AddressWidth(AW)) bus ();

  logic [31:0] mem [0:MEMW-1];

  int testsRun;
  int testsFailed;
  int cycle;
  int acceptCycle;
  int enCount;
  int rspCount;
  int rspCycle;
  logic [31:0] rspData;
  logic        rspErr;
  int          logAddr  [0:7];
  logic [3:0]  logBe    [0:7];
  logic [31:0] logWdata [0:7];
  logic        logWe    [0:7];

  load_store_unit #(.AddressWidth(AW)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (bus.req_valid),
    .req_ready_o  (bus.req_ready),
    .req_we_i     (bus.req_we),
    .req_addr_i   (bus.req_addr),
    .req_wdata_i  (bus.req_wdata),
    .req_funct3_i (bus.req_funct3),
    .rsp_valid_o  (bus.rsp_valid),
    .rsp_rdata_o  (bus.rsp_rdata),
    .rsp_err_o    (bus.rsp_err),
    .mem_en_o     (bus.mem_en),
    .mem_we_o     (bus.mem_we),
    .mem_addr_o   (bus.mem_addr),
    .mem_be_o     (bus.mem_be),
    .mem_wdata_o  (bus.mem_wdata),
    .mem_rdata_i  (bus.mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle = cycle + 1;

  // Synchronous memory: read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_be[b]) mem[bus.mem_addr][8*b +: 8] = bus.mem_wdata[8*b +: 8];
      end else begin
        bus.mem_rdata <= mem[bus.mem_addr];
      end
    end
  end

  always @(negedge clk) begin
    if (bus.mem_en && enCount < 8) begin
      logAddr[enCount]  = int'(bus.mem_addr);
      logBe[enCount]    = bus.mem_be;
      logWdata[enCount] = bus.mem_wdata;
      logWe[enCount]    = bus.mem_we;
      enCount = enCount + 1;
    end
    if (bus.rsp_valid) begin
      rspCount = rspCount + 1;
      rspCycle = cycle;
      rspData  = bus.rsp_rdata;
      rspErr   = bus.rsp_err;
    end
  end

  task automatic applyRequest(input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [2:0] f3);
    @(negedge clk);
    enCount  = 0;
    rspCount = 0;
    rspCycle = -1;
    testsRun++;
    if (bus.req_ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL ready_before_req: got %b expected 1", bus.req_ready);
    end
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_funct3 = f3;
    acceptCycle    = cycle;
    @(posedge clk);
    #1;
    bus.req_valid  = 1'b0;
    bus.req_we     = ~we;
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
    bus.req_funct3 = 3'b011;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    testsRun++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.mem_en, bus.mem_we} !== 5'b10000) begin
      testsFailed++;
      $display("[TB] FAIL reset_flags: got %b expected 10000",
               {bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.mem_en, bus.mem_we});
    end
    testsRun++;
    if ({bus.rsp_rdata, bus.mem_wdata, bus.mem_be, bus.mem_addr} !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_buses: rdata %h wdata %h be %b addr %h expected all 0",
               bus.rsp_rdata, bus.mem_wdata, bus.mem_be, bus.mem_addr);
    end
    rst = 1'b0;
    @(negedge clk);
    testsRun++;
    if (bus.req_ready !== 1'b1 || enCount != 0) begin
      testsFailed++;
      $display("[TB] FAIL reset_release: ready %b strobes %0d expected 1/0", bus.req_ready, enCount);
    end
  endtask

  task automatic test_lw;
    mem[4] = 32'hDEADBEEF;
    applyRequest(1'b0, 32'h10, 32'h0, F3_W);
    repeat (5) @(negedge clk);
    testsRun++;
    if (rspCount != 1 || rspCycle - acceptCycle != 2) begin
      testsFailed++;
      $display("[TB] FAIL lw_timing: count %0d delay %0d expected 1/2", rspCount, rspCycle - acceptCycle);
    end
    testsRun++;
    if (rspData !== 32'hDEADBEEF || rspErr !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL lw_data: got %h err %b expected deadbeef err 0", rspData, rspErr);
    end
    testsRun++;
    if (enCount != 1 || logAddr[0] != 4 || logBe[0] !== 4'b1111 || logWe[0] !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL lw_strobe: n %0d addr %0d be %b we %b expected 1/4/1111/0",
               enCount, logAddr[0], logBe[0], logWe[0]);
    end
  endtask

  task automatic test_sub_word_loads;
    logic [2:0]  f3s   [4] = '{F3_B, F3_BU, F3_H, F3_HU};
    logic [31:0] addrs [4] = '{32'h13, 32'h13, 32'h12, 32'h12};
    logic [31:0] exps  [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF};
    mem[4] = 32'h80FFFFFF;
    for (int i = 0; i < 4; i++) begin
      applyRequest(1'b0, addrs[i], 32'h0, f3s[i]);
      repeat (5) @(negedge clk);
      testsRun++;
      if (rspCount != 1 || rspData !== exps[i] || rspCycle - acceptCycle != 2) begin
        testsFailed++;
        $display("[TB] FAIL subword_load_%0d: got %h count %0d delay %0d expected %h/1/2",
                 i, rspData, rspCount, rspCycle - acceptCycle, exps[i]);
      end
    end
  endtask

  task automatic test_sw_crossing;
    mem[3] = 32'h11111111;
    mem[4] = 32'h22222222;
    applyRequest(1'b1, 32'h0E, 32'hAABBCCDD, F3_W);
    repeat (6) @(negedge clk);
    testsRun++;
    if (rspCount != 1 || rspCycle - acceptCycle != 3 || rspData !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL sw_rsp: count %0d delay %0d rdata %h expected 1/3/0",
               rspCount, rspCycle - acceptCycle, rspData);
    end
    testsRun++;
    if (enCount != 2 || logAddr[0] != 3 || logBe[0] !== 4'b1100 || logWdata[0] !== 32'hCCDD0000
        || logWe[0] !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL sw_acc0: n %0d addr %0d be %b data %h we %b expected 2/3/1100/ccdd0000/1",
               enCount, logAddr[0], logBe[0], logWdata[0], logWe[0]);
    end
    testsRun++;
    if (logAddr[1] != 4 || logBe[1] !== 4'b0011 || logWdata[1] !== 32'h0000AABB || logWe[1] !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL sw_acc1: addr %0d be %b data %h we %b expected 4/0011/0000aabb/1",
               logAddr[1], logBe[1], logWdata[1], logWe[1]);
    end
    testsRun++;
    if (mem[3] !== 32'hCCDD1111 || mem[4] !== 32'h2222AABB) begin
      testsFailed++;
      $display("[TB] FAIL sw_memory: got %h %h expected ccdd1111 2222aabb", mem[3], mem[4]);
    end
    applyRequest(1'b0, 32'h0E, 32'h0, F3_W);
    repeat (6) @(negedge clk);
    testsRun++;
    if (rspData !== 32'hAABBCCDD || rspCycle - acceptCycle != 3 || enCount != 2) begin
      testsFailed++;
      $display("[TB] FAIL lw_crossing: got %h delay %0d strobes %0d expected aabbccdd/3/2",
               rspData, rspCycle - acceptCycle, enCount);
    end
  endtask

  task automatic test_sb;
    mem[8] = 32'hFFFFFFFF;
    applyRequest(1'b1, 32'h21, 32'h1234565A, F3_B);
    repeat (5) @(negedge clk);
    testsRun++;
    if (enCount != 1 || logBe[0] !== 4'b0010 || logWdata[0] !== 32'h34565A00 || logAddr[0] != 8
        || rspCycle - acceptCycle != 2) begin
      testsFailed++;
      $display("[TB] FAIL sb_strobe: n %0d be %b data %h addr %0d delay %0d expected 1/0010/34565a00/8/2",
               enCount, logBe[0], logWdata[0], logAddr[0], rspCycle - acceptCycle);
    end
    testsRun++;
    if (mem[8] !== 32'hFFFF5AFF) begin
      testsFailed++;
      $display("[TB] FAIL sb_memory: got %h expected ffff5aff", mem[8]);
    end
  endtask

  task automatic test_wrap;
    mem[MEMW-1] = 32'hAB000000;
    mem[0]      = 32'h000000CD;
    applyRequest(1'b0, 32'(4 * MEMW - 1), 32'h0, F3_H);
    repeat (6) @(negedge clk);
    testsRun++;
    if (enCount != 2 || logAddr[0] != MEMW - 1 || logAddr[1] != 0) begin
      testsFailed++;
      $display("[TB] FAIL wrap_addr: n %0d addrs %0d %0d expected 2/%0d/0",
               enCount, logAddr[0], logAddr[1], MEMW - 1);
    end
    testsRun++;
    if (rspData !== 32'hFFFFCDAB || rspCycle - acceptCycle != 3) begin
      testsFailed++;
      $display("[TB] FAIL wrap_data: got %h delay %0d expected ffffcdab/3", rspData, rspCycle - acceptCycle);
    end
  endtask

  task automatic test_error;
    applyRequest(1'b0, 32'h10, 32'h0, 3'b011);
    repeat (4) @(negedge clk);
    testsRun++;
    if (rspCount != 1 || rspErr !== 1'b1 || rspData !== 32'h0 || rspCycle - acceptCycle != 1 || enCount != 0) begin
      testsFailed++;
      $display("[TB] FAIL err_load: count %0d err %b data %h delay %0d strobes %0d expected 1/1/0/1/0",
               rspCount, rspErr, rspData, rspCycle - acceptCycle, enCount);
    end
    applyRequest(1'b1, 32'h10, 32'h12345678, F3_BU);
    repeat (4) @(negedge clk);
    testsRun++;
    if (rspCount != 1 || rspErr !== 1'b1 || rspCycle - acceptCycle != 1 || enCount != 0) begin
      testsFailed++;
      $display("[TB] FAIL err_store: count %0d err %b delay %0d strobes %0d expected 1/1/1/0",
               rspCount, rspErr, rspCycle - acceptCycle, enCount);
    end
  endtask

  task automatic test_reset_mid_access;
    mem[3] = 32'h01020304;
    mem[4] = 32'h05060708;
    applyRequest(1'b0, 32'h0E, 32'h0, F3_W);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    testsRun++;
    if ({bus.req_ready, bus.mem_en, bus.rsp_valid, bus.mem_be} !== 7'b1000000 || bus.mem_addr !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_async: ready %b en %b rsp %b be %b addr %h expected 1/0/0/0000/0",
               bus.req_ready, bus.mem_en, bus.rsp_valid, bus.mem_be, bus.mem_addr);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    testsRun++;
    if (rspCount != 0 || enCount != 2) begin
      testsFailed++;
      $display("[TB] FAIL reset_abandon: responses %0d strobes %0d expected 0/2", rspCount, enCount);
    end
    mem[4] = 32'hCAFEF00D;
    applyRequest(1'b0, 32'h10, 32'h0, F3_W);
    repeat (5) @(negedge clk);
    testsRun++;
    if (rspCount != 1 || rspData !== 32'hCAFEF00D || rspCycle - acceptCycle != 2) begin
      testsFailed++;
      $display("[TB] FAIL reset_recover: count %0d data %h delay %0d expected 1/cafef00d/2",
               rspCount, rspData, rspCycle - acceptCycle);
    end
  endtask

  initial begin
    testsRun       = 0;
    testsFailed    = 0;
    cycle          = 0;
    enCount        = 0;
    rspCount       = 0;
    rspCycle       = -1;
    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.req_funct3 = 3'b000;
    bus.mem_rdata  = 32'h0;
    for (int i = 0; i < MEMW; i++) mem[i] = 32'h0;
    test_reset();
    test_lw();
    test_sub_word_loads();
    test_sw_crossing();
    test_sb();
    test_wrap();
    test_error();
    test_reset_mid_access();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
